// File: rtl/tree_vote_sequencer.sv
// Ensemble sequencer: shares one 1-bit tree evaluator across NUM_TREES trees,
// accumulates their votes and returns the majority class over valid/ready.
module tree_vote_sequencer #(
  parameter int unsigned FEAT_W    = 51,
  parameter int unsigned NUM_TREES = 5,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FEAT_W-1:0] in_feat,
  output logic [FEAT_W-1:0] tree_feat,
  output logic [SEL_W-1:0]  tree_sel,
  input  logic              tree_vote,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_class,
  output logic [CNT_W-1:0]  out_votes,
  output logic              busy
);

  // Majority compare runs one bit wider than the count so 2*votes cannot wrap.
  localparam int unsigned CMP_W = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [FEAT_W-1:0]   feat_q, feat_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    votes_q, votes_d;
  logic                class_q, class_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    sum;
  logic                accept;

  // Input handshake: idle, or handing off a result in the same cycle; never during clear.
  assign in_ready = ~clear & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    feat_d  = feat_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    votes_d = votes_q;
    class_d = class_q;
    valid_d = valid_q;
    sum     = cnt_q + CNT_W'(tree_vote);

    if (clear) begin
      state_d = IDLE;
      valid_d = 1'b0;
      cnt_d   = '0;
      sel_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            feat_d  = in_feat;
            sel_d   = '0;
            cnt_d   = '0;
            state_d = EVAL;
          end
        end
        EVAL: begin
          cnt_d = sum;
          if (sel_q == SEL_W'(NUM_TREES - 1)) begin
            state_d = DONE;
            votes_d = sum;
            class_d = ({sum, 1'b0} > CMP_W'(NUM_TREES));
            valid_d = 1'b1;
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_d = 1'b0;
            if (accept) begin
              feat_d  = in_feat;
              sel_d   = '0;
              cnt_d   = '0;
              state_d = EVAL;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      feat_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      votes_q <= '0;
      class_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      feat_q  <= feat_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      votes_q <= votes_d;
      class_q <= class_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign tree_feat = feat_q;
  assign tree_sel  = sel_q;
  assign out_valid = valid_q;
  assign out_class = class_q;
  assign out_votes = votes_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_tree_vote_sequencer.sv
// Directed bench for tree_vote_sequencer: 5-tree and 4-tree instances with a
// lookup-table evaluator model driven by tree_sel.
module tb_tree_vote_sequencer;

  localparam int unsigned FEAT_W = 51;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 5-tree instance
  logic              clear, in_valid, in_ready, out_valid, out_ready, out_class, busy, tree_vote;
  logic [FEAT_W-1:0] in_feat, tree_feat;
  logic [2:0]        tree_sel, out_votes;
  logic [7:0]        vote_pat;
  assign tree_vote = vote_pat[tree_sel];

  tree_vote_sequencer #(.FEAT_W(FEAT_W), .NUM_TREES(5), .SEL_W(3), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_feat(in_feat), .tree_feat(tree_feat), .tree_sel(tree_sel), .tree_vote(tree_vote),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_votes(out_votes), .busy(busy)
  );

  // 4-tree instance (even count: tie rule)
  logic              clear4, in_valid4, in_ready4, out_valid4, out_ready4, out_class4, busy4, tree_vote4;
  logic [FEAT_W-1:0] in_feat4, tree_feat4;
  logic [2:0]        tree_sel4, out_votes4;
  logic [7:0]        vote_pat4;
  assign tree_vote4 = vote_pat4[tree_sel4];

  tree_vote_sequencer #(.FEAT_W(FEAT_W), .NUM_TREES(4), .SEL_W(3), .CNT_W(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear4), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_feat(in_feat4), .tree_feat(tree_feat4), .tree_sel(tree_sel4), .tree_vote(tree_vote4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_class(out_class4),
    .out_votes(out_votes4), .busy(busy4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one vector to the 5-tree instance; returns at T+1.
  task automatic launch(input logic [FEAT_W-1:0] f);
    in_valid = 1'b1;
    in_feat  = f;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b expected 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else n_pass++;
    n_checks++; if (tree_sel !== 3'd0) $display("FAIL reset_tree_sel: got %0d expected 0", tree_sel); else n_pass++;
    n_checks++; if (tree_feat !== '0) $display("FAIL reset_tree_feat: got %0h expected 0", tree_feat); else n_pass++;
    n_checks++; if ({out_class, out_votes} !== 4'd0) $display("FAIL reset_result: got %0h expected 0", {out_class, out_votes}); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b expected 1", in_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [FEAT_W-1:0] f;
    f = 51'h5_A5A5_1234_5678;
    vote_pat = 8'b0000_1101;  // trees 0..4 vote 1,0,1,1,0
    launch(f);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (tree_sel !== 3'(i)) $display("FAIL single_sel[%0d]: got %0d expected %0d", i, tree_sel, i); else n_pass++;
      n_checks++; if (tree_feat !== f || out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL single_eval[%0d]: feat=%0h valid=%0b rdy=%0b busy=%0b expected feat=%0h 0 0 1", i, tree_feat, out_valid, in_ready, busy, f);
      else n_pass++;
      step();
    end
    n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %0b expected 1", out_valid); else n_pass++;
    n_checks++; if (out_votes !== 3'd3) $display("FAIL single_votes: got %0d expected 3", out_votes); else n_pass++;
    n_checks++; if (out_class !== 1'b1) $display("FAIL single_class: got %0b expected 1", out_class); else n_pass++;
    n_checks++; if (tree_sel !== 3'd4) $display("FAIL single_sel_hold: got %0d expected 4", tree_sel); else n_pass++;
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL single_done_ready: got %0b expected 1", in_ready); else n_pass++;
    step();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_drain: valid=%0b busy=%0b expected 0 0", out_valid, busy); else n_pass++;
  endtask

  task automatic test_minority();
    vote_pat = 8'b0001_0010;  // votes 0,1,0,0,1
    launch(51'h1);
    repeat (5) step();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_valid !== 1'b1 || out_votes !== 3'd2 || out_class !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL minority_hold[%0d]: valid=%0b votes=%0d class=%0b rdy=%0b busy=%0b expected 1 2 0 0 1", i, out_valid, out_votes, out_class, in_ready, busy);
      else n_pass++;
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL minority_drain: got %0b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [FEAT_W-1:0] f2;
    f2 = 51'h7_0000_0000_00AB;
    vote_pat = 8'b0001_1111;
    launch(51'h2);
    repeat (5) step();
    n_checks++; if (out_votes !== 3'd5 || out_class !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL b2b_first: votes=%0d class=%0b valid=%0b expected 5 1 1", out_votes, out_class, out_valid);
    else n_pass++;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_feat   = f2;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %0b expected 1", in_ready); else n_pass++;
    step();
    in_valid = 1'b0;
    vote_pat = 8'b0000_0000;
    n_checks++; if (tree_sel !== 3'd0 || tree_feat !== f2 || out_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_restart: sel=%0d feat=%0h valid=%0b busy=%0b expected 0 %0h 0 1", tree_sel, tree_feat, out_valid, busy, f2);
    else n_pass++;
    repeat (4) step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_early: got %0b expected 0", out_valid); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_votes !== 3'd0 || out_class !== 1'b0)
      $display("FAIL b2b_second: valid=%0b votes=%0d class=%0b expected 1 0 0", out_valid, out_votes, out_class);
    else n_pass++;
    step();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %0b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_clear();
    logic [FEAT_W-1:0] f_old, f_new;
    f_old = 51'h3_3333_3333_3333;
    f_new = 51'h4_4444_4444_4444;
    vote_pat = 8'b0001_1111;
    launch(f_old);
    repeat (2) step();
    n_checks++; if (tree_sel !== 3'd2) $display("FAIL clear_pre_sel: got %0d expected 2", tree_sel); else n_pass++;
    clear    = 1'b1;
    in_valid = 1'b1;
    in_feat  = f_new;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL clear_in_ready: got %0b expected 0", in_ready); else n_pass++;
    step();
    clear = 1'b0;
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || tree_sel !== 3'd0 || tree_feat !== f_old)
      $display("FAIL clear_idle: busy=%0b valid=%0b sel=%0d feat=%0h expected 0 0 0 %0h", busy, out_valid, tree_sel, tree_feat, f_old);
    else n_pass++;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL clear_ready_after: got %0b expected 1", in_ready); else n_pass++;
    step();
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || tree_sel !== 3'd0 || tree_feat !== f_new)
      $display("FAIL clear_reaccept: busy=%0b sel=%0d feat=%0h expected 1 0 %0h", busy, tree_sel, tree_feat, f_new);
    else n_pass++;
    repeat (5) step();
    n_checks++; if (out_valid !== 1'b1 || out_votes !== 3'd5)
      $display("FAIL clear_result: valid=%0b votes=%0d expected 1 5", out_valid, out_votes);
    else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_eval();
    vote_pat = 8'b0001_1111;
    launch(51'h6_DEAD_BEEF_0001);
    step();  // now at T+2
    n_checks++; if (tree_sel !== 3'd1 || busy !== 1'b1) $display("FAIL rst_mid_pre: sel=%0d busy=%0b expected 1 1", tree_sel, busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (tree_sel !== 3'd0 || tree_feat !== '0 || busy !== 1'b0 || out_valid !== 1'b0 || out_votes !== 3'd0 || out_class !== 1'b0)
      $display("FAIL rst_mid_async: sel=%0d feat=%0h busy=%0b valid=%0b votes=%0d class=%0b expected all 0", tree_sel, tree_feat, busy, out_valid, out_votes, out_class);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rst_mid_idle: rdy=%0b busy=%0b expected 1 0", in_ready, busy); else n_pass++;
  endtask

  // Runs one transaction on the 4-tree instance with the given vote table.
  task automatic test_tie(input logic [7:0] pat, input logic [2:0] exp_votes, input logic exp_class);
    vote_pat4 = pat;
    in_valid4 = 1'b1;
    in_feat4  = 51'h0_0F0F_0F0F_0F0F;
    step();
    in_valid4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (tree_sel4 !== 3'(i)) $display("FAIL tie_sel[%0d]: got %0d expected %0d", i, tree_sel4, i); else n_pass++;
      step();
    end
    n_checks++; if (out_valid4 !== 1'b1 || out_votes4 !== exp_votes || out_class4 !== exp_class || tree_sel4 !== 3'd3)
      $display("FAIL tie_result: valid=%0b votes=%0d class=%0b sel=%0d expected 1 %0d %0b 3", out_valid4, out_votes4, out_class4, tree_sel4, exp_votes, exp_class);
    else n_pass++;
    out_ready4 = 1'b1;
    step();
    out_ready4 = 1'b0;
    n_checks++; if (out_valid4 !== 1'b0) $display("FAIL tie_drain: got %0b expected 0", out_valid4); else n_pass++;
  endtask

  initial begin
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_feat = '0; vote_pat = '0;
    clear4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0; in_feat4 = '0; vote_pat4 = '0;
    rst_n = 1'b1;
    #2;
    test_reset();
    test_single();
    test_minority();
    test_back_to_back();
    test_clear();
    test_reset_mid_eval();
    test_tie(8'b0000_0011, 3'd2, 1'b0);
    test_tie(8'b0000_1111, 3'd4, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tree_vote_sequencer.md
Name: tree_vote_sequencer

Overview:
- Time-multiplexes one shared single-bit decision-tree evaluator across NUM_TREES trees to form an ensemble classifier.
- Accepts one feature vector per transaction and holds it stable on the evaluator input. Steps the tree select one tree per cycle and accumulates the 1-bit votes.
- Returns the majority class and the vote count over a valid/ready output channel.
- Sits between the feature source and the combinational tree mux (`class*_tree*` instances behind a select).

Parameters:
- FEAT_W, 51, width of feature vector; matches tree evaluator input.
- NUM_TREES, 5, number of trees in the ensemble; legal range 1..255.
- SEL_W, 3, width of tree_sel; must satisfy 2**SEL_W >= NUM_TREES.
- CNT_W, 3, width of vote count; must satisfy 2**CNT_W > NUM_TREES.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- clear, input, 1, synchronous flush; aborts any transaction and returns to IDLE.
- in_valid, input, 1, feature vector offered.
- in_ready, output, 1, sequencer can accept a feature vector.
- in_feat, input, FEAT_W, feature vector.
- tree_feat, output, FEAT_W, registered feature vector driven to the shared evaluator.
- tree_sel, output, SEL_W, index of the tree being evaluated.
- tree_vote, input, 1, combinational evaluator result for (tree_feat, tree_sel).
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts result.
- out_class, output, 1, majority class.
- out_votes, output, CNT_W, number of trees that voted 1.
- busy, output, 1, high in EVAL or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - tree_feat, tree_sel, vote count, out_class and out_votes = 0.
  - out_valid=0, busy=0.
- States: IDLE, EVAL, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). in_ready is forced 0 while clear=1.
- Accept = in_valid & in_ready. On accept:
  - tree_feat <= in_feat.
  - tree_sel <= 0.
  - vote count <= 0.
  - state <= EVAL.
- EVAL, each cycle:
  - count += tree_vote, sampled for the current tree_sel.
  - If tree_sel == NUM_TREES-1: state <= DONE. Load out_votes with the final count, including this cycle's vote. Compute out_class.
  - Otherwise: tree_sel += 1.
  - tree_feat is held constant throughout EVAL.
- Majority rule: out_class = 1 iff 2*out_votes > NUM_TREES. Strict, so an even-NUM_TREES tie gives 0. Compare at CNT_W+1 bits with no overflow.
- DONE:
  - out_valid=1, busy=1.
  - out_class and out_votes are held stable until out_ready.
  - On out_ready with no accept: state <= IDLE, out_valid <= 0.
  - On out_ready with accept in the same cycle: go directly to EVAL with the new vector. This gives back-to-back throughput of one result per NUM_TREES+1 cycles.
- Latency: accept at cycle T. Votes are sampled at T+1..T+NUM_TREES. out_valid is high from T+NUM_TREES+1.
- NUM_TREES=1: EVAL lasts one cycle and tree_sel stays 0.
- tree_sel never exceeds NUM_TREES-1. It returns to 0 only on accept, reset or clear.
- clear (synchronous, highest priority after reset):
  - state <= IDLE, out_valid <= 0.
  - Count and tree_sel <= 0.
  - tree_feat is retained.
  - No result is emitted for the aborted transaction.
- in_valid in EVAL is ignored and in_ready stays 0. The source must hold in_valid and in_feat until accepted.
- out_valid never drops without out_ready or clear.

Test Plan:
- Reset mid-EVAL: assert rst_n=0 asynchronously at cycle T+2 -> all outputs 0 immediately, state IDLE, in_ready=1 after release.
- Single transaction, NUM_TREES=5, votes 1,0,1,1,0 -> tree_sel 0,1,2,3,4 on cycles T+1..T+5, out_valid at T+6, out_votes=3, out_class=1.
- Minority, votes 0,1,0,0,1 -> out_votes=2, out_class=0. Hold out_ready=0 for 4 cycles -> outputs stable, in_ready=0.
- Back-to-back: out_ready=1 and in_valid=1 in DONE -> new vector accepted the same cycle, tree_sel=0 next cycle, second result 6 cycles after first.
- clear asserted at tree_sel=2 with in_valid=1 -> no out_valid, in_ready=0 during clear, IDLE next cycle, then new accept.
- NUM_TREES=4, votes 1,1,0,0 -> out_votes=2, out_class=0 (tie rule); all-ones -> out_votes=4, out_class=1.
